fft_frame_feeder: RTL and testbench

FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

---
 rtl/fft_pkg.sv | 18 +
 rtl/frame_bank.sv | 47 ++++
 rtl/fft_frame_feeder.sv | 170 +++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath types: sample width, complex sample struct and the
// frame feeder's read-side state encoding.
package fft_pkg;

    localparam int DATA_WIDTH = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_BURST,
        RD_GAP
    } rd_state_t;

endpackage

// File: rtl/frame_bank.sv
// One frame of complex sample storage: single write port, single read port
// with a registered read that holds its value when no read is issued.
module frame_bank
    import fft_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  complex_t          wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output complex_t          rd_data
);

    complex_t mem [DEPTH];
    complex_t rd_data_d;
    complex_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // The read register doubles as the feeder's output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer that collects upstream samples into FFT_SIZE frames
// and replays each as a gap-free burst into a streaming FFT core.
module fft_frame_feeder
    import fft_pkg::*;
#(
    parameter int FFT_SIZE = 16,
    parameter int MIN_GAP  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_valid,
    output logic                  out_first
);

    localparam int ADDR_W = $clog2(FFT_SIZE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FFT_SIZE - 1);
    localparam logic [3:0] GAP_LAST = 4'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);

    rd_state_t         state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [1:0]        full_q, full_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_first_q, out_first_d;
    logic              out_bank_q, out_bank_d;

    logic              accept;
    logic              wr_done;
    logic              other_full;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    complex_t          wr_data;
    complex_t          rd_data0;
    complex_t          rd_data1;

    assign in_ready = !full_q[wr_bank_q];
    assign accept   = in_valid && in_ready;
    assign wr_done  = accept && (wr_idx_q == LAST_IDX);
    assign wr_data  = '{re: in_re, im: in_im};

    // A frame completing on the same edge a burst ends still counts as
    // ready, so the next burst follows without a bubble.
    assign other_full = full_q[~rd_bank_q] || (wr_done && (wr_bank_q != rd_bank_q));

    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        full_d      = full_q;
        gap_cnt_d   = gap_cnt_q;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_bank_d  = out_bank_q;
        rd_en       = 1'b0;
        rd_addr     = rd_idx_q;

        if (accept) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (wr_done) begin
                wr_idx_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_en       = 1'b1;
                    rd_addr     = '0;
                    out_valid_d = 1'b1;
                    out_first_d = 1'b1;
                    out_bank_d  = rd_bank_q;
                    rd_idx_d    = ADDR_W'(1);
                    state_d     = RD_BURST;
                end
            end
            RD_BURST: begin
                rd_en       = 1'b1;
                out_valid_d = 1'b1;
                out_first_d = (rd_idx_q == '0);
                out_bank_d  = rd_bank_q;
                rd_idx_d    = rd_idx_q + 1'b1;
                if (rd_idx_q == LAST_IDX) begin
                    rd_idx_d          = '0;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    if (MIN_GAP == 0) begin
                        state_d = other_full ? RD_BURST : RD_IDLE;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = RD_GAP;
                    end
                end
            end
            RD_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = full_q[rd_bank_q] ? RD_BURST : RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            full_q      <= '0;
            gap_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_bank_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            full_q      <= full_d;
            gap_cnt_q   <= gap_cnt_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_bank_q  <= out_bank_d;
        end
    end

    frame_bank #(.DEPTH(FFT_SIZE)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept && !wr_bank_q),
        .wr_addr (wr_idx_q),
        .wr_data (wr_data),
        .rd_en   (rd_en && !rd_bank_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data0)
    );

    frame_bank #(.DEPTH(FFT_SIZE)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept && wr_bank_q),
        .wr_addr (wr_idx_q),
        .wr_data (wr_data),
        .rd_en   (rd_en && rd_bank_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    assign out_re    = out_bank_q ? rd_data1.re : rd_data0.re;
    assign out_im    = out_bank_q ? rd_data1.im : rd_data0.im;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: two instances (MIN_GAP 0 and 4) checked against
// a frame-level timing model built from the recorded accept stream.
module tb_fft_frame_feeder;
    import fft_pkg::*;

    localparam int N = 16;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef struct { word_t re; word_t im; int cyc; } acc_t;
    typedef struct { word_t re; word_t im; logic first; int cyc; } out_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  in_valid_v [2];
    word_t in_re_v [2];
    word_t in_im_v [2];
    logic  in_ready_v [2];
    logic  out_valid_v [2];
    logic  out_first_v [2];
    word_t out_re_v [2];
    word_t out_im_v [2];

    fft_frame_feeder #(.FFT_SIZE(N), .MIN_GAP(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_re(in_re_v[0]), .in_im(in_im_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .out_re(out_re_v[0]), .out_im(out_im_v[0]), .out_valid(out_valid_v[0]), .out_first(out_first_v[0])
    );

    fft_frame_feeder #(.FFT_SIZE(N), .MIN_GAP(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_re(in_re_v[1]), .in_im(in_im_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .out_re(out_re_v[1]), .out_im(out_im_v[1]), .out_valid(out_valid_v[1]), .out_first(out_first_v[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int act = 0;
    int n_cmp = 0;
    int n_err = 0;
    int ready_low = 0;
    acc_t acc_q[$];
    out_t out_q[$];
    out_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepts (tagged with their accepting edge) and emitted samples.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid_v[act] && in_ready_v[act])
                acc_q.push_back(acc_t'{in_re_v[act], in_im_v[act], cyc + 1});
            if (!in_ready_v[act]) ready_low++;
            if (out_valid_v[act])
                out_q.push_back(out_t'{out_re_v[act], out_im_v[act], out_first_v[act], cyc});
        end
    end

    // Each complete frame starts one cycle after its last accept, but not before
    // the previous frame's last sample plus the configured gap.
    function automatic void build_exp(input int gap);
        int prev_end;
        int start;
        prev_end = -1000;
        exp_q.delete();
        for (int f = 0; f < acc_q.size() / N; f++) begin
            start = acc_q[f*N + N - 1].cyc + 1;
            if (prev_end + gap + 1 > start) start = prev_end + gap + 1;
            for (int j = 0; j < N; j++)
                exp_q.push_back(out_t'{acc_q[f*N + j].re, acc_q[f*N + j].im, (j == 0), start + j});
            prev_end = start + N - 1;
        end
    endfunction

    // With upstream always valid, a frame-start sample waits for the bank two
    // frames back to finish emitting; all others follow one per cycle.
    function automatic int exp_acc_cyc(input int i);
        int e;
        e = acc_q[i-1].cyc + 1;
        if (i % N == 0 && i >= 2*N && exp_q.size() > (i/N - 2)*N + N - 1)
            if (exp_q[(i/N - 2)*N + N - 1].cyc + 1 > e) e = exp_q[(i/N - 2)*N + N - 1].cyc + 1;
        return e;
    endfunction

    task automatic clear_rec(input int d);
        act = d;
        acc_q.delete();
        out_q.delete();
        ready_low = 0;
    endtask

    task automatic send(input int d, input word_t re, input word_t im);
        int n;
        n = 0;
        in_re_v[d] = re;
        in_im_v[d] = im;
        in_valid_v[d] = 1'b1;
        @(negedge clk);
        while (!in_ready_v[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_v[d]) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout dut%0d: in_ready=0 after 200 cycles, required 1", d);
        end
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
    endtask

    task automatic drain(input int nexp);
        int n;
        n = 0;
        while (out_q.size() < nexp && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (out_valid_v[d] !== 1'b0 || out_first_v[d] !== 1'b0 || out_re_v[d] !== '0 ||
                out_im_v[d] !== '0 || in_ready_v[d] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_state dut%0d: got v=%b f=%b re=%h im=%h rdy=%b, required v=0 f=0 re=0 im=0 rdy=1",
                         d, out_valid_v[d], out_first_v[d], out_re_v[d], out_im_v[d], in_ready_v[d]);
            end
        end
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        clear_rec(0);
        for (int k = 0; k < 3*N; k++) send(0, word_t'(k), word_t'(-k));
        drain(3*N);
        build_exp(0);
        n_cmp++;
        if (out_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL stream_count: got %0d outputs, required %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i].re !== exp_q[i].re || out_q[i].im !== exp_q[i].im ||
                out_q[i].first !== exp_q[i].first || out_q[i].cyc != exp_q[i].cyc) begin
                n_err++;
                $display("FAIL stream[%0d]: got re=%h im=%h first=%b cyc=%0d, required re=%h im=%h first=%b cyc=%0d",
                         i, out_q[i].re, out_q[i].im, out_q[i].first, out_q[i].cyc,
                         exp_q[i].re, exp_q[i].im, exp_q[i].first, exp_q[i].cyc);
            end
        end
        for (int i = 1; i < acc_q.size(); i++) begin
            n_cmp++;
            if (acc_q[i].cyc != exp_acc_cyc(i)) begin
                n_err++;
                $display("FAIL stream_accept[%0d]: got edge %0d, required %0d", i, acc_q[i].cyc, exp_acc_cyc(i));
            end
        end
    endtask

    task automatic test_single_frame();
        clear_rec(0);
        for (int k = 0; k < N; k++) send(0, word_t'($urandom), word_t'($urandom));
        drain(N);
        build_exp(0);
        n_cmp++;
        if (out_q.size() != N) begin
            n_err++;
            $display("FAIL single_count: got %0d outputs, required %0d", out_q.size(), N);
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i].re !== exp_q[i].re || out_q[i].im !== exp_q[i].im ||
                out_q[i].first !== exp_q[i].first || out_q[i].cyc != exp_q[i].cyc) begin
                n_err++;
                $display("FAIL single[%0d]: got re=%h im=%h first=%b cyc=%0d, required re=%h im=%h first=%b cyc=%0d",
                         i, out_q[i].re, out_q[i].im, out_q[i].first, out_q[i].cyc,
                         exp_q[i].re, exp_q[i].im, exp_q[i].first, exp_q[i].cyc);
            end
        end
        n_cmp++;
        if (ready_low != 0) begin
            n_err++;
            $display("FAIL single_in_ready: got %0d cycles low, required 0", ready_low);
        end
    endtask

    task automatic test_gap();
        clear_rec(1);
        for (int k = 0; k < 4*N; k++) send(1, word_t'($urandom), word_t'($urandom));
        drain(4*N);
        build_exp(4);
        n_cmp++;
        if (out_q.size() != exp_q.size() || exp_q.size() != 4*N) begin
            n_err++;
            $display("FAIL gap_count: got %0d outputs, required %0d", out_q.size(), 4*N);
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i].re !== exp_q[i].re || out_q[i].im !== exp_q[i].im ||
                out_q[i].first !== exp_q[i].first || out_q[i].cyc != exp_q[i].cyc) begin
                n_err++;
                $display("FAIL gap[%0d]: got re=%h im=%h first=%b cyc=%0d, required re=%h im=%h first=%b cyc=%0d",
                         i, out_q[i].re, out_q[i].im, out_q[i].first, out_q[i].cyc,
                         exp_q[i].re, exp_q[i].im, exp_q[i].first, exp_q[i].cyc);
            end
        end
        for (int i = 1; i < acc_q.size(); i++) begin
            n_cmp++;
            if (acc_q[i].cyc != exp_acc_cyc(i)) begin
                n_err++;
                $display("FAIL gap_accept[%0d]: got edge %0d, required %0d", i, acc_q[i].cyc, exp_acc_cyc(i));
            end
        end
    endtask

    task automatic test_random(input int d);
        clear_rec(d);
        for (int k = 0; k < 20*N; k++) begin
            while ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            send(d, word_t'($urandom), word_t'($urandom));
        end
        drain(20*N);
        build_exp(d == 1 ? 4 : 0);
        n_cmp++;
        if (out_q.size() != 20*N || exp_q.size() != 20*N) begin
            n_err++;
            $display("FAIL random_count dut%0d: got %0d outputs, required %0d", d, out_q.size(), 20*N);
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i].re !== exp_q[i].re || out_q[i].im !== exp_q[i].im ||
                out_q[i].first !== exp_q[i].first || out_q[i].cyc != exp_q[i].cyc) begin
                n_err++;
                $display("FAIL random%0d[%0d]: got re=%h im=%h first=%b cyc=%0d, required re=%h im=%h first=%b cyc=%0d",
                         d, i, out_q[i].re, out_q[i].im, out_q[i].first, out_q[i].cyc,
                         exp_q[i].re, exp_q[i].im, exp_q[i].first, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_rec(0);
        for (int k = 0; k < 7; k++) send(0, word_t'(k + 50), word_t'(k + 60));
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid_v[0] !== 1'b0 || out_first_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_partial: got v=%b f=%b rdy=%b, required v=0 f=0 rdy=1",
                     out_valid_v[0], out_first_v[0], in_ready_v[0]);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_rec(0);
        for (int k = 0; k < N; k++) send(0, word_t'(k + 100), word_t'(k + 120));
        n = 0;
        while (out_q.size() < 9 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        build_exp(0);
        n_cmp++;
        if (out_q.size() != 9) begin
            n_err++;
            $display("FAIL rst_burst_reach: got %0d outputs before reset, required 9", out_q.size());
        end
        for (int i = 0; i < 9 && i < out_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (out_q[i].re !== exp_q[i].re || out_q[i].im !== exp_q[i].im || out_q[i].first !== exp_q[i].first) begin
                n_err++;
                $display("FAIL rst_pre[%0d]: got re=%h im=%h first=%b, required re=%h im=%h first=%b",
                         i, out_q[i].re, out_q[i].im, out_q[i].first, exp_q[i].re, exp_q[i].im, exp_q[i].first);
            end
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid_v[0] !== 1'b0 || out_first_v[0] !== 1'b0 || out_re_v[0] !== '0 ||
            out_im_v[0] !== '0 || in_ready_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_midburst: got v=%b f=%b re=%h im=%h rdy=%b, required v=0 f=0 re=0 im=0 rdy=1",
                     out_valid_v[0], out_first_v[0], out_re_v[0], out_im_v[0], in_ready_v[0]);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_rec(0);
        for (int k = 0; k < N; k++) send(0, word_t'(k + 200), word_t'(k + 220));
        drain(N);
        build_exp(0);
        n_cmp++;
        if (out_q.size() != N) begin
            n_err++;
            $display("FAIL rst_clean_count: got %0d outputs, required %0d", out_q.size(), N);
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i].re !== exp_q[i].re || out_q[i].im !== exp_q[i].im ||
                out_q[i].first !== exp_q[i].first || out_q[i].cyc != exp_q[i].cyc) begin
                n_err++;
                $display("FAIL rst_clean[%0d]: got re=%h im=%h first=%b cyc=%0d, required re=%h im=%h first=%b cyc=%0d",
                         i, out_q[i].re, out_q[i].im, out_q[i].first, out_q[i].cyc,
                         exp_q[i].re, exp_q[i].im, exp_q[i].first, exp_q[i].cyc);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b0;
            in_re_v[d] = '0;
            in_im_v[d] = '0;
        end
        test_reset();
        test_stream();
        test_single_frame();
        test_gap();
        test_random(0);
        test_random(1);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
